// File: rtl/shift_add_pkg.sv
// Shared FSM states and Q shift-register command codes for the shift-add multiplier.
package shift_add_pkg;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_e;

  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_SHR  = 2'b01;
  localparam logic [1:0] SR_SHL  = 2'b10;
  localparam logic [1:0] SR_LOAD = 2'b11;

endpackage

// File: rtl/shift_add_shift_reg.sv
// Q register holding the multiplier: hold, shift right/left with serial fill, or parallel load.
// Single-cycle update; no backpressure, the command is applied on every edge.
module shift_add_shift_reg
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ctrl,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else begin
      case (ctrl)
        SR_HOLD: r_q <= r_q;
        SR_SHR:  r_q <= {ser_in, r_q[WIDTH-1:1]};
        SR_SHL:  r_q <= {r_q[WIDTH-2:0], ser_in};
        SR_LOAD: r_q <= parallel_in;
      endcase
    end
  end

  assign parallel_out = r_q;

endmodule

// File: rtl/shift_add_sequencer.sv
// Control and accumulator stage of the shift-add multiplier; product ready 2W+1 cycles after start.
// Starts arriving while busy or in DONE are dropped, not queued.
module shift_add_sequencer
  import shift_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   sr_parallel_out,
  output logic [1:0]         sr_ctrl,
  output logic               sr_ser_in,
  output logic [WIDTH-1:0]   sr_parallel_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_m;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_sum;

  // The extra bit keeps the carry out of A+M so the full 2W-bit product never overflows.
  assign w_sum = {1'b0, r_a} + {1'b0, r_m};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_m     <= multiplicand;
            r_a     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          if (sr_parallel_out[0]) begin
            {r_c, r_a} <= w_sum;
          end
          r_state <= SHIFT;
        end
        SHIFT: begin
          r_a   <= {r_c, r_a[WIDTH-1:1]};
          r_c   <= 1'b0;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= ADD;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Q loads in the same edge that accepts start, so the load command is driven from IDLE.
  always_comb begin
    sr_ctrl   = SR_HOLD;
    sr_ser_in = 1'b0;
    case (r_state)
      IDLE:    if (start) sr_ctrl = SR_LOAD;
      SHIFT: begin
        sr_ctrl   = SR_SHR;
        sr_ser_in = r_a[0];
      end
      default: sr_ctrl = SR_HOLD;
    endcase
  end

  assign sr_parallel_in = multiplier;
  assign busy           = r_busy;
  assign done           = r_done;
  assign product        = {r_a, sr_parallel_out};

endmodule

// File: tb/tb_shift_add_sequencer.sv
// Bench for the sequencer plus its Q shift register at W=8: directed operations against a cycle model.
module tb_shift_add_sequencer;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic [W-1:0]   sr_parallel_out;
  logic [1:0]     sr_ctrl;
  logic           sr_ser_in;
  logic [W-1:0]   sr_parallel_in;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  shift_add_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .sr_parallel_out(sr_parallel_out), .sr_ctrl(sr_ctrl), .sr_ser_in(sr_ser_in),
    .sr_parallel_in(sr_parallel_in), .busy(busy), .done(done), .product(product)
  );

  shift_add_shift_reg #(.WIDTH(W)) u_q (
    .clk(clk), .rst(rst), .ctrl(sr_ctrl), .ser_in(sr_ser_in),
    .parallel_in(sr_parallel_in), .parallel_out(sr_parallel_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Cycle model: offset k from the accepting cycle decides every output; the bit
  // shifted out of A in iteration j is bit j of the final product.
  bit             m_act  = 1'b0;
  int             m_k    = 0;
  logic [2*W-1:0] m_p    = '0;
  logic [2*W-1:0] m_prod = '0;

  always @(negedge clk) begin
    logic [1:0] e_ctrl;
    logic       e_busy, e_done, e_ser;
    if (rst) begin
      m_act  = 1'b0;
      m_prod = '0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ctrl", 32'(sr_ctrl), 32'd0);
      chk("rst_ser", 32'(sr_ser_in), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
    end else begin
      if (m_act) m_k++;
      if (m_act && m_k == 2*W + 2) m_act = 1'b0;
      if (!m_act && start) begin
        m_act = 1'b1;
        m_k   = 0;
        m_p   = (2*W)'(multiplicand) * (2*W)'(multiplier);
      end
      e_ctrl = 2'b00; e_busy = 1'b0; e_done = 1'b0; e_ser = 1'b0;
      if (m_act) begin
        if (m_k == 0) e_ctrl = 2'b11;
        else if (m_k <= 2*W) begin
          e_busy = 1'b1;
          if (m_k % 2 == 0) begin
            e_ctrl = 2'b01;
            e_ser  = m_p[m_k/2 - 1];
          end
        end else begin
          e_done = 1'b1;
          m_prod = m_p;
        end
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("sr_ctrl", 32'(sr_ctrl), 32'(e_ctrl));
      chk("sr_ser_in", 32'(sr_ser_in), 32'(e_ser));
      chk("sr_parallel_in", 32'(sr_parallel_in), 32'(multiplier));
      if (!m_act || m_k == 0 || m_k == 2*W + 1)
        chk("product", 32'(product), 32'(m_prod));
    end
  end

  logic [1:0] rec_ctrl [0:39];
  logic [7:0] rec_ser;

  // One operation: start for a single cycle, optional second start at cycle 5, measure latency.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input bit inject, input string nm);
    int lat, busy_n;
    @(posedge clk); #1;
    multiplicand = a; multiplier = b; start = 1'b1;
    lat = -1; busy_n = 0; rec_ser = '0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      rec_ctrl[i] = sr_ctrl;
      if (i >= 2 && i <= 2*W && i % 2 == 0) rec_ser[i/2 - 1] = sr_ser_in;
      if (busy) busy_n++;
      if (done) lat = i;
      @(posedge clk); #1;
      start = 1'b0;
      if (inject && i == 3) begin
        start = 1'b1; multiplicand = 8'd1; multiplier = 8'd1;
      end
    end
    chk({nm, "_latency"}, 32'(lat), 32'd17);
    chk({nm, "_busy_cycles"}, 32'(busy_n), 32'd16);
    chk({nm, "_product"}, 32'(product), 32'(exp));
    @(negedge clk);
    chk({nm, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dcyc [$];
    int seen;
    rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(8'd13,  8'd11,  16'h008F, 1'b0, "13x11");
    run_op(8'd255, 8'd255, 16'hFE01, 1'b0, "255x255");
    run_op(8'd0,   8'd200, 16'h0000, 1'b0, "0x200");
    run_op(8'd200, 8'd0,   16'h0000, 1'b0, "200x0");
    run_op(8'd13,  8'd11,  16'd143,  1'b1, "ignored_start");

    run_op(8'd5, 8'd3, 16'd15, 1'b0, "5x3");
    chk("5x3_ctrl_first", 32'(rec_ctrl[0]), 32'd3);
    for (int i = 1; i <= 2*W; i++)
      chk("5x3_ctrl_seq", 32'(rec_ctrl[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    chk("5x3_ctrl_last", 32'(rec_ctrl[17]), 32'd0);
    chk("5x3_ser_bits", 32'(rec_ser), 32'h0F);

    // Held start: back-to-back operations every 18 cycles.
    @(posedge clk); #1;
    multiplicand = 8'd3; multiplier = 8'd5; start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) dcyc.push_back(i);
    end
    @(posedge clk); #1 start = 1'b0;
    chk("b2b_count", 32'(dcyc.size()), 32'd3);
    if (dcyc.size() == 3) begin
      chk("b2b_first", 32'(dcyc[0]), 32'd17);
      chk("b2b_gap1", 32'(dcyc[1] - dcyc[0]), 32'd18);
      chk("b2b_gap2", 32'(dcyc[2] - dcyc[1]), 32'd18);
    end
    repeat (25) @(posedge clk);

    // Reset in the middle of 13x11 aborts it with no done pulse.
    #1 multiplicand = 8'd13; multiplier = 8'd11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ctrl", 32'(sr_ctrl), 32'd0);
    chk("midrst_product", 32'(product), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_op(8'd7, 8'd6, 16'd42, 1'b0, "7x6");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
